// File: rtl/dvi_pixel_fifo.sv
// Prefetch FIFO from the framebuffer reader to the DVI output stage, with a registered head word.
// Define DVI_PIXFIFO_UNDERFLOW_COLOR_EN to show a magenta marker on underflow instead of repeating the last pixel.
module dvi_pixel_fifo #(
  parameter int DEPTH     = 16,
  parameter int LOW_WATER = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [63:0]              wr_data,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic                     request,
  output logic [63:0]              data,
  input  logic                     flush,
  output logic                     fill_req,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE   = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   LVL_ONE   = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   LVL_FULL  = DEPTH[AW:0];
  localparam logic [AW:0]   LVL_LOW   = LOW_WATER[AW:0];
  localparam logic [63:0]   UNDERFLOW_COLOR = 64'hFF00_FF00_FF00_FF00;

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q, level_d;
  logic [63:0]   data_q;
  logic          head_valid_q, underflow_q, fill_req_q, wr_ready_q;
  logic          push, load, starve;

  always_comb begin
    push    = wr_valid && wr_ready_q && !flush;
    load    = (!head_valid_q || request) && (level_q != '0) && !flush;
    starve  = request && (level_q == '0) && !flush;
    level_d = level_q;
    if (push && !load) begin
      level_d = level_q + LVL_ONE;
    end else if (load && !push) begin
      level_d = level_q - LVL_ONE;
    end
  end

  // Storage has no reset so it can map onto block RAM; pointers alone define validity.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      data_q       <= '0;
      head_valid_q <= 1'b0;
      underflow_q  <= 1'b0;
      fill_req_q   <= 1'b0;
      wr_ready_q   <= 1'b0;
    end else if (flush) begin
      // Flush leaves the sticky underflow flag alone and blocks writes for one cycle.
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      data_q       <= '0;
      head_valid_q <= 1'b0;
      fill_req_q   <= 1'b0;
      wr_ready_q   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (load) begin
        rd_ptr_q     <= rd_ptr_q + PTR_ONE;
        data_q       <= mem[rd_ptr_q];
        head_valid_q <= 1'b1;
      end else if (starve) begin
        head_valid_q <= 1'b0;
`ifdef DVI_PIXFIFO_UNDERFLOW_COLOR_EN
        data_q       <= UNDERFLOW_COLOR;
`endif
      end
      if (request && ((level_q == '0) || !head_valid_q)) begin
        underflow_q <= 1'b1;
      end
      level_q    <= level_d;
      fill_req_q <= (level_d <= LVL_LOW);
      wr_ready_q <= (level_d < LVL_FULL);
    end
  end

`ifndef DVI_PIXFIFO_UNDERFLOW_COLOR_EN
  logic unused_color;
  assign unused_color = ^UNDERFLOW_COLOR;
`endif

  assign data      = data_q;
  assign level     = level_q;
  assign fill_req  = fill_req_q;
  assign wr_ready  = wr_ready_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_dvi_pixel_fifo.sv
// Randomized bench for dvi_pixel_fifo against a queue-based reference model.
// Directed phases follow the usage scenarios; random phase mixes writes, requests and flushes.
module tb_dvi_pixel_fifo;
  localparam int DEPTH     = 16;
  localparam int LOW_WATER = 4;
  localparam logic [63:0] MAGENTA = 64'hFF00_FF00_FF00_FF00;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] wr_data = '0;
  logic        wr_valid = 1'b0;
  logic        request = 1'b0;
  logic        flush = 1'b0;
  logic        wr_ready, fill_req, underflow;
  logic [63:0] data;
  logic [4:0]  level;

  always #5 clock = ~clock;

  dvi_pixel_fifo #(.DEPTH(DEPTH), .LOW_WATER(LOW_WATER)) dut (
    .clock(clock), .reset(reset), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .request(request), .data(data), .flush(flush),
    .fill_req(fill_req), .level(level), .underflow(underflow)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: queue of stored words plus the presented head word.
  logic [63:0] mq[$];
  logic [63:0] m_data = '0;
  bit m_hv = 0, m_uf = 0, m_fill = 0, m_rdy = 0;
  logic [63:0] next_word = 64'h100;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc %0d got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_edge();
    bit acc;
    int n;
    if (reset) begin
      mq.delete(); m_data = '0; m_hv = 0; m_uf = 0; m_fill = 0; m_rdy = 0;
    end else if (flush) begin
      mq.delete(); m_data = '0; m_hv = 0; m_fill = 0; m_rdy = 0;
    end else begin
      acc = wr_valid && m_rdy;
      n = mq.size();
      if (request && (n == 0 || !m_hv)) m_uf = 1;
      if ((!m_hv || request) && n > 0) begin
        m_data = mq.pop_front();
        m_hv = 1;
      end else if (request) begin
        m_hv = 0;
`ifdef DVI_PIXFIFO_UNDERFLOW_COLOR_EN
        m_data = MAGENTA;
`endif
      end
      if (acc) mq.push_back(wr_data);
      m_fill = (mq.size() <= LOW_WATER);
      m_rdy  = (mq.size() < DEPTH);
    end
  endtask

  // One clock edge: update model, then compare every output 1 ns later.
  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    cyc++;
    $display("cyc %0d rst %0b wv %0b wd %h req %0b fl %0b | data %h lvl %0d fr %0b rdy %0b uf %0b",
             cyc, reset, wr_valid, wr_data, request, flush, data, level, fill_req, wr_ready, underflow);
    check("data", data, m_data);
    check("level", 64'(level), 64'(mq.size()));
    check("fill_req", 64'(fill_req), 64'(m_fill));
    check("wr_ready", 64'(wr_ready), 64'(m_rdy));
    check("underflow", 64'(underflow), 64'(m_uf));
  endtask

  // Advance one edge; upstream keeps an unaccepted word stable and only moves on after acceptance.
  task automatic step_hold();
    bit acc;
    acc = wr_valid && wr_ready && !flush && !reset;
    step();
    if (acc) begin
      next_word = next_word + 64'(1 + $urandom_range(0, 7));
      wr_data = next_word ^ {32'($urandom), 32'h0};
    end
  endtask

  initial begin
    // Reset held for two edges.
    step();
    step();
    check("rst_wr_ready", 64'(wr_ready), 64'd0);
    check("rst_fill_req", 64'(fill_req), 64'd0);
    reset = 1'b0;
    step();
    check("rel_wr_ready", 64'(wr_ready), 64'd1);
    check("rel_fill_req", 64'(fill_req), 64'd1);

    // Push 1..4 back-to-back with no request.
    for (int i = 1; i <= 4; i++) begin
      wr_valid = 1'b1;
      wr_data = 64'(i);
      step();
    end
    wr_valid = 1'b0;
    check("first_data", data, 64'h1);
    check("first_level", 64'(level), 64'd3);
    check("first_fill", 64'(fill_req), 64'd1);

    // Fill until full; upstream holds the blocked word.
    wr_valid = 1'b1;
    wr_data = 64'hA000;
    for (int i = 0; i < 24; i++) step_hold();
    check("full_level", 64'(level), 64'd16);
    check("full_ready", 64'(wr_ready), 64'd0);
    request = 1'b1;
    step_hold();
    request = 1'b0;
    step_hold();
    check("refill_level", 64'(level), 64'd16);
    wr_valid = 1'b0;

    // Steady state: write and request every cycle.
    wr_valid = 1'b1;
    request = 1'b1;
    for (int i = 0; i < 30; i++) step_hold();
    check("steady_uf", 64'(underflow), 64'd0);

    // Drain, then keep requesting into an empty FIFO.
    wr_valid = 1'b0;
    for (int i = 0; i < 22; i++) step();
    request = 1'b0;
    step();
    check("drain_uf", 64'(underflow), 64'd1);
    step();
    check("uf_sticky", 64'(underflow), 64'd1);

    // Flush with level 8 together with a write and a request.
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    wr_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      wr_data = 64'h5000 + 64'(i);
      step();
    end
    wr_valid = 1'b0;
    step();
    check("pre_flush_level", 64'(level), 64'd8);
    flush = 1'b1;
    wr_valid = 1'b1;
    wr_data = 64'hDEAD;
    request = 1'b1;
    step();
    flush = 1'b0;
    wr_valid = 1'b0;
    request = 1'b0;
    check("flush_level", 64'(level), 64'd0);
    check("flush_data", data, 64'd0);
    check("flush_fill", 64'(fill_req), 64'd0);
    check("flush_ready", 64'(wr_ready), 64'd0);
    step();
    check("post_flush_fill", 64'(fill_req), 64'd1);
    check("post_flush_ready", 64'(wr_ready), 64'd1);

    // Reset mid-stream at level 10, then recover.
    wr_valid = 1'b1;
    for (int i = 0; i < 11; i++) begin
      wr_data = 64'h7000 + 64'(i);
      step();
    end
    check("pre_reset_level", 64'(level), 64'd10);
    reset = 1'b1;
    request = 1'b1;
    step();
    check("mid_rst_data", data, 64'd0);
    check("mid_rst_level", 64'(level), 64'd0);
    check("mid_rst_uf", 64'(underflow), 64'd0);
    check("mid_rst_ready", 64'(wr_ready), 64'd0);
    reset = 1'b0;
    request = 1'b0;
    wr_valid = 1'b0;
    step();
    wr_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_data = 64'h9000 + 64'(i);
      step();
    end
    wr_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      request = 1'b1;
      step();
    end
    request = 1'b0;

    // Random traffic; unaccepted words are held stable by the upstream.
    wr_data = 64'hB000;
    for (int i = 0; i < 400; i++) begin
      if (!(wr_valid && !wr_ready)) wr_valid = ($urandom_range(0, 3) != 0);
      request = ($urandom_range(0, 2) == 0);
      flush = ($urandom_range(0, 39) == 0);
      step_hold();
    end
    wr_valid = 1'b0;
    request = 1'b0;
    flush = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
